// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
//
// Multi-cycle WIDTH-bit subtractor, diff = a - b, evaluated as a + ~b + 1
// one 4-bit nibble per clock through a carry-lookahead slice. The carry
// between nibbles is held in a register.
//
// Optional build macro: SUB_SIGNED_OVF_EN
//   defined   -> ovf reports signed overflow of a - b, updated with done
//   undefined -> ovf is tied to 0 and no sign logic is built
//
// Parameters:
//   WIDTH   operand/result width; must be a multiple of 4 and at least 8
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   operation request, sampled only while idle
//   a, b    minuend and subtrahend (captured on start)
//   busy    high while an operation is in flight
//   done    one-cycle pulse, result and flags valid
//   diff    a - b modulo 2^WIDTH
//   borrow  unsigned a < b
//   zero    diff == 0
//   neg     diff MSB
//   ovf     signed overflow (see macro above)

module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] aR_q, aR_d;
    logic [WIDTH-1:0] bR_q, bR_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [3:0] x, y, p, g, sum;
    logic [4:0] c;

    // Pick the operand nibbles addressed by the step counter.
    always_comb begin
        x = '0;
        y = '0;
        for (int n = 0; n < NIB; n++) begin
            if (cnt_q == CW'(n)) begin
                x = aR_q[4*n +: 4];
                y = bR_q[4*n +: 4];
            end
        end
    end

    // 4-bit carry-lookahead slice; every carry is formed directly from
    // generate/propagate terms and the incoming carry, never rippled.
    always_comb begin
        p    = x ^ y;
        g    = x & y;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
    end

    // Nibbles accumulate in res_q so the visible diff keeps the previous
    // result until the new one is complete.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        aR_d     = aR_q;
        bR_d     = bR_q;
        res_d    = res_q;
        diff_d   = diff_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        neg_d    = neg_q;

        if (state_q == IDLE) begin
            if (start) begin
                aR_d    = a;
                bR_d    = ~b;
                carry_d = 1'b1;
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = RUN;
            end
        end else begin
            for (int n = 0; n < NIB; n++) begin
                if (cnt_q == CW'(n)) begin
                    res_d[4*n +: 4] = sum;
                end
            end
            carry_d = c[4];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                diff_d   = res_d;
                borrow_d = ~c[4];
                zero_d   = (res_d == '0);
                neg_d    = res_d[WIDTH-1];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            aR_q     <= '0;
            bR_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            aR_q     <= aR_d;
            bR_q     <= bR_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_q, ovf_d;
    logic signA, signB;

    // B_r holds ~b, so its MSB is inverted back to recover the sign of b.
    always_comb begin
        signA = aR_q[WIDTH-1];
        signB = ~bR_q[WIDTH-1];
        ovf_d = ovf_q;
        if ((state_q == RUN) && (cnt_q == LAST)) begin
            ovf_d = (signA != signB) && (res_d[WIDTH-1] != signA);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign neg    = neg_q;

endmodule
